jtframe_rom_slots: RTL and testbench



---
 rtl/jtframe_rom_slots_if.sv | 28 ++
 rtl/jtframe_rom_slots.sv | 157 +++++++++++++++
 tb/tb_jtframe_rom_slots.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_rom_slots_if.sv
// Bus between the ROM request clients, the SDRAM read port and the slot responder.
// The responder takes the slave modport; the clients and SDRAM controller side take the master modport.
interface jtframe_rom_slots_if #(
    parameter int SLOTS  = 4,
    parameter int SDRAMW = 22
);
    logic [SLOTS-1:0]        slot_req;
    logic [SLOTS*SDRAMW-1:0] slot_addr;
    logic [SLOTS-1:0]        slot_we;
    logic [SLOTS-1:0]        slot_dst;
    logic [SLOTS-1:0]        slot_din_ok;
    logic [15:0]             slot_din;
    logic                    sdram_rd;
    logic [SDRAMW-1:0]       sdram_addr;
    logic                    sdram_ack;
    logic                    sdram_dok;
    logic [15:0]             sdram_din;

    modport master (
        output slot_req, slot_addr, sdram_ack, sdram_dok, sdram_din,
        input  slot_we, slot_dst, slot_din_ok, slot_din, sdram_rd, sdram_addr
    );

    modport slave (
        input  slot_req, slot_addr, sdram_ack, sdram_dok, sdram_din,
        output slot_we, slot_dst, slot_din_ok, slot_din, sdram_rd, sdram_addr
    );
endinterface

// File: rtl/jtframe_rom_slots.sv
// Round-robin SDRAM responder: grants one ROM client at a time, issues one read burst
// and steers the returned words back to that client with we/dst/din_ok strobes.
module jtframe_rom_slots #(
    parameter int SLOTS  = 4,
    parameter int SDRAMW = 22,
    parameter int BURST  = 2
) (
    input  logic               clk,
    input  logic               rst,
    jtframe_rom_slots_if.slave bus,
    output logic               busy,
    output logic [1:0]         sel
);
    localparam int            CW      = $clog2(BURST) + 1;
    localparam logic [CW-1:0] BURST_C = CW'(BURST);
    localparam logic [1:0]    PTR_RST = 2'(SLOTS - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DATA, HOLD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [SLOTS-1:0]  we_q, we_d;
    logic [SLOTS-1:0]  dst_q, dst_d;
    logic [SLOTS-1:0]  ok_q, ok_d;
    logic [15:0]       din_q, din_d;

    logic              found;
    logic [1:0]        grant;
    logic [SDRAMW-1:0] grant_addr;
    logic [SLOTS-1:0]  sel_oh;
    logic              take_word;
    logic [CW-1:0]     cnt_inc;

    // Search slots above the pointer first, then wrap to the ones at or below it.
    always_comb begin
        found      = 1'b0;
        grant      = '0;
        grant_addr = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && bus.slot_req[i] && (2'(i) > ptr_q)) begin
                found      = 1'b1;
                grant      = 2'(i);
                grant_addr = bus.slot_addr[i*SDRAMW +: SDRAMW];
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && bus.slot_req[i] && (2'(i) <= ptr_q)) begin
                found      = 1'b1;
                grant      = 2'(i);
                grant_addr = bus.slot_addr[i*SDRAMW +: SDRAMW];
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < SLOTS; i++) begin
            sel_oh[i] = (sel_q == 2'(i));
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        we_d      = we_q;
        dst_d     = '0;
        ok_d      = '0;
        din_d     = din_q;
        take_word = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = grant;
                    addr_d  = grant_addr;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    rd_d      = 1'b0;
                    state_d   = WAIT;
                    take_word = bus.sdram_dok;
                end
            end
            WAIT, DATA: take_word = bus.sdram_dok;
            HOLD: begin
                we_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A word may also land on the ack cycle, so word handling sits outside the case.
        if (take_word) begin
            din_d   = bus.sdram_din;
            ok_d    = sel_oh;
            we_d    = sel_oh;
            cnt_d   = cnt_inc;
            state_d = DATA;
            if (cnt_q == '0) begin
                dst_d = sel_oh;
            end
            if (cnt_inc == BURST_C) begin
                ptr_d   = sel_q;
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            we_q    <= '0;
            dst_q   <= '0;
            ok_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            dst_q   <= dst_d;
            ok_q    <= ok_d;
            din_q   <= din_d;
        end
    end

    assign bus.sdram_rd    = rd_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.slot_we     = we_q;
    assign bus.slot_dst    = dst_q;
    assign bus.slot_din_ok = ok_q;
    assign bus.slot_din    = din_q;
    assign busy            = (state_q != IDLE);
    assign sel             = sel_q;
endmodule

// File: tb/tb_jtframe_rom_slots.sv
// Bench for jtframe_rom_slots: one BURST=2 and one BURST=4 responder behind a shared
// client/SDRAM driver, checked against a transaction-level round-robin model.
module tb_jtframe_rom_slots;
    logic        clk = 1'b0;
    logic        rst;
    logic        use4;
    logic [3:0]  req;
    logic [87:0] addr;
    logic        ack;
    logic        dok;
    logic [15:0] din_in;

    logic        busy2, busy4;
    logic [1:0]  sel2, sel4;

    int          checks = 0;
    int          errors = 0;
    int          last_ptr[2];
    logic [15:0] last_word;
    logic [15:0] wq[4];
    logic [21:0] lat_addr;
    int          we_n, ok_n, dst_n;

    jtframe_rom_slots_if #(.SLOTS(4), .SDRAMW(22)) bus2 ();
    jtframe_rom_slots_if #(.SLOTS(4), .SDRAMW(22)) bus4 ();

    assign bus2.slot_req  = use4 ? 4'b0 : req;
    assign bus2.slot_addr = addr;
    assign bus2.sdram_ack = use4 ? 1'b0 : ack;
    assign bus2.sdram_dok = use4 ? 1'b0 : dok;
    assign bus2.sdram_din = din_in;
    assign bus4.slot_req  = use4 ? req : 4'b0;
    assign bus4.slot_addr = addr;
    assign bus4.sdram_ack = use4 ? ack : 1'b0;
    assign bus4.sdram_dok = use4 ? dok : 1'b0;
    assign bus4.sdram_din = din_in;

    jtframe_rom_slots #(.SLOTS(4), .SDRAMW(22), .BURST(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus2.slave),
        .busy (busy2),
        .sel  (sel2)
    );

    jtframe_rom_slots #(.SLOTS(4), .SDRAMW(22), .BURST(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus4.slave),
        .busy (busy4),
        .sel  (sel4)
    );

    wire [3:0]  o_we   = use4 ? bus4.slot_we     : bus2.slot_we;
    wire [3:0]  o_dst  = use4 ? bus4.slot_dst    : bus2.slot_dst;
    wire [3:0]  o_dok  = use4 ? bus4.slot_din_ok : bus2.slot_din_ok;
    wire [15:0] o_din  = use4 ? bus4.slot_din    : bus2.slot_din;
    wire        o_rd   = use4 ? bus4.sdram_rd    : bus2.sdram_rd;
    wire [21:0] o_addr = use4 ? bus4.sdram_addr  : bus2.sdram_addr;
    wire        o_busy = use4 ? busy4 : busy2;
    wire [1:0]  o_sel  = use4 ? sel4  : sel2;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tally();
        if (o_we  != 4'b0) we_n++;
        if (o_dok != 4'b0) ok_n++;
        if (o_dst != 4'b0) dst_n++;
    endtask

    // Reference arbiter: first pending slot after the last one served, wrapping round.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    task automatic check_reset(input string tag);
        checkOutput({tag, "_we"},   o_we,   0);
        checkOutput({tag, "_dst"},  o_dst,  0);
        checkOutput({tag, "_dok"},  o_dok,  0);
        checkOutput({tag, "_din"},  o_din,  0);
        checkOutput({tag, "_rd"},   o_rd,   0);
        checkOutput({tag, "_addr"}, o_addr, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_sel"},  o_sel,  0);
    endtask

    task automatic wait_grant(output int slot, output int lat);
        logic [3:0] ra;
        int exp;
        lat = 0;
        ra  = req;
        do begin
            ra = req;
            step();
            lat++;
        end while (!o_rd && lat < 16);
        checkOutput("grant_seen", o_rd, 1);
        exp      = rr_pick(ra, last_ptr[use4]);
        lat_addr = addr[exp*22 +: 22];
        checkOutput("grant_sel",  o_sel,  exp);
        checkOutput("grant_addr", o_addr, lat_addr);
        checkOutput("grant_busy", o_busy, 1);
        slot = exp;
    endtask

    task automatic serve(input int slot, input int ack_dly, input bit coincide,
                         input logic [3:0] gaps, input bit drop);
        logic [3:0] oh;
        int b, first, exp_we;
        oh     = 4'b1 << slot;
        b      = use4 ? 4 : 2;
        exp_we = b;
        we_n   = 0;
        ok_n   = 0;
        dst_n  = 0;
        for (int i = 0; i < ack_dly; i++) begin
            step();
            tally();
            checkOutput("rd_held", o_rd, 1);
        end
        ack = 1'b1;
        if (coincide) begin
            dok    = 1'b1;
            din_in = wq[0];
        end
        step();
        tally();
        ack = 1'b0;
        dok = 1'b0;
        checkOutput("rd_released", o_rd, 0);
        if (drop) req[slot] = 1'b0;
        first = 0;
        if (coincide) begin
            checkOutput("co_ok",  o_dok, oh);
            checkOutput("co_din", o_din, wq[0]);
            checkOutput("co_dst", o_dst, oh);
            first = 1;
        end
        for (int w = first; w < b; w++) begin
            if (gaps[w]) begin
                step();
                tally();
                if (w > 0) exp_we++;
                checkOutput("gap_ok", o_dok, 0);
                checkOutput("gap_we", o_we, (w > 0) ? oh : 4'b0);
            end
            dok    = 1'b1;
            din_in = wq[w];
            step();
            tally();
            dok = 1'b0;
            checkOutput("word_ok",  o_dok, oh);
            checkOutput("word_din", o_din, wq[w]);
            checkOutput("word_dst", o_dst, (w == 0) ? oh : 4'b0);
            checkOutput("word_we",  o_we,  oh);
        end
        checkOutput("hold_busy", o_busy, 1);
        step();
        checkOutput("idle_we",     o_we,   0);
        checkOutput("idle_ok",     o_dok,  0);
        checkOutput("idle_busy",   o_busy, 0);
        checkOutput("addr_stable", o_addr, lat_addr);
        checkOutput("we_cycles",   we_n,   exp_we);
        checkOutput("ok_cycles",   ok_n,   b);
        checkOutput("dst_cycles",  dst_n,  1);
        last_ptr[use4] = slot;
        last_word      = wq[b-1];
    endtask

    task automatic applyStimulus(input int n);
        int s, l;
        for (int it = 0; it < n; it++) begin
            req  = 4'($urandom_range(1, 15));
            addr = {24'($urandom), 32'($urandom), 32'($urandom)};
            for (int w = 0; w < 4; w++) wq[w] = 16'($urandom);
            wait_grant(s, l);
            addr = {24'($urandom), 32'($urandom), 32'($urandom)};
            serve(s, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  4'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int s, l;
        int rr_order[6] = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1; use4 = 1'b0; req = '0; addr = '0;
        ack = 1'b0; dok = 1'b0; din_in = '0;
        last_ptr[0] = 3; last_ptr[1] = 3; last_word = '0;
        step(); step(); step();
        check_reset("reset");
        rst = 1'b0;

        $display("[TB] single slot burst");
        addr[21:0] = 22'h000100;
        req        = 4'b0001;
        wq[0]      = 16'h1234;
        wq[1]      = 16'h5678;
        wait_grant(s, l);
        checkOutput("single_latency", l, 1);
        checkOutput("single_addr", o_addr, 22'h000100);
        serve(s, 0, 1'b0, 4'b0, 1'b1);
        step();
        checkOutput("single_busy_after", o_busy, 0);

        $display("[TB] stray sdram_dok in idle");
        req    = 4'b0;
        dok    = 1'b1;
        din_in = 16'hdead;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stray_ok",   o_dok,  0);
            checkOutput("stray_we",   o_we,   0);
            checkOutput("stray_din",  o_din,  last_word);
            checkOutput("stray_busy", o_busy, 0);
        end
        dok = 1'b0;

        $display("[TB] round robin from reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_ptr[0] = 3; last_ptr[1] = 3;
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < 4; w++) wq[w] = 16'($urandom);
            wait_grant(s, l);
            checkOutput("rr_order", o_sel, rr_order[i]);
            serve(s, 0, 1'b0, 4'b0, 1'b0);
        end
        req = 4'b0;

        $display("[TB] gap and req drop");
        req = 4'b0100;
        wq[0] = 16'h0a0a;
        wq[1] = 16'h0b0b;
        wait_grant(s, l);
        checkOutput("gap_slot", o_sel, 2);
        serve(s, 1, 1'b0, 4'b0010, 1'b1);

        $display("[TB] reset mid burst");
        req = 4'b0100;
        wait_grant(s, l);
        ack = 1'b1;
        step();
        ack    = 1'b0;
        dok    = 1'b1;
        din_in = 16'hbeef;
        step();
        dok = 1'b0;
        checkOutput("pre_rst_we", o_we, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        req = 4'b1111;
        step(); step();
        rst = 1'b0;
        last_ptr[0] = 3; last_ptr[1] = 3;
        for (int w = 0; w < 4; w++) wq[w] = 16'($urandom);
        wait_grant(s, l);
        checkOutput("rst_first_grant", o_sel, 0);
        serve(s, 0, 1'b0, 4'b0, 1'b1);

        $display("[TB] random bursts, BURST=2");
        applyStimulus(20);

        $display("[TB] ack with first word, BURST=4");
        req  = 4'b0;
        step();
        use4 = 1'b1;
        req  = 4'b1000;
        for (int w = 0; w < 4; w++) wq[w] = 16'($urandom);
        wait_grant(s, l);
        checkOutput("co_slot", o_sel, 3);
        serve(s, 0, 1'b1, 4'b0, 1'b0);

        $display("[TB] random bursts, BURST=4");
        applyStimulus(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
